// File: rtl/rip_writeback_if.sv
// rip_writeback_if: EX/MA issue, data-memory response and register-file write bundle.
interface rip_writeback_if;
  logic        ex_valid;
  logic        ex_rd_wen;
  logic [4:0]  ex_rd_num;
  logic        ex_is_load;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  logic [31:0] ex_result;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_ready;
  logic        wen;
  logic [4:0]  ma_rd_num;
  logic [31:0] wdata;
  logic        pend_valid;
  logic [4:0]  pend_rd_num;
  logic        err_timeout;
  modport master (
    output ex_valid, ex_rd_wen, ex_rd_num, ex_is_load, ex_funct3, ex_addr_lo, ex_result,
           dmem_rvalid, dmem_rdata,
    input  wb_ready, wen, ma_rd_num, wdata, pend_valid, pend_rd_num, err_timeout
  );
  modport slave (
    input  ex_valid, ex_rd_wen, ex_rd_num, ex_is_load, ex_funct3, ex_addr_lo, ex_result,
           dmem_rvalid, dmem_rdata,
    output wb_ready, wen, ma_rd_num, wdata, pend_valid, pend_rd_num, err_timeout
  );
endinterface

// File: rtl/rip_writeback.sv
// rip_writeback: MA/WB stage; writes ALU results directly, waits for and extends load data, aborts stalled loads.
module rip_writeback #(
  parameter int unsigned LOAD_TIMEOUT = 255
) (
  input logic            clk,
  input logic            rst,
  rip_writeback_if.slave bus
);
  typedef enum logic {IDLE, WAIT_LOAD} state_t;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d, ma_rd_q, ma_rd_d;
  logic        rd_wen_q, rd_wen_d, wen_q, wen_d, err_q, err_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] wdata_q, wdata_d, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  assign ld_byte = bus.dmem_rdata[{lo_q, 3'b111} -: 8];
  assign ld_half = bus.dmem_rdata[{lo_q[1], 4'hF} -: 16];
  // funct3[2] selects zero-extension; funct3 3/6/7 fall through to the full word
  assign ld_data = f3_q[1:0] == 2'd0 ? {{24{~f3_q[2] & ld_byte[7]}}, ld_byte}
                 : f3_q[1:0] == 2'd1 ? {{16{~f3_q[2] & ld_half[15]}}, ld_half}
                 : bus.dmem_rdata;
  assign bus.wb_ready    = state_q == IDLE;
  assign bus.wen         = wen_q;
  assign bus.ma_rd_num   = ma_rd_q;
  assign bus.wdata       = wdata_q;
  assign bus.pend_valid  = state_q == WAIT_LOAD;
  assign bus.pend_rd_num = rd_q;
  assign bus.err_timeout = err_q;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    rd_wen_d = rd_wen_q;
    f3_d     = f3_q;
    lo_d     = lo_q;
    wen_d    = 1'b0;
    ma_rd_d  = ma_rd_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    if (state_q == IDLE) begin
      if (bus.ex_valid && bus.ex_is_load) begin
        state_d  = WAIT_LOAD;
        cnt_d    = '0;
        rd_d     = bus.ex_rd_num;
        rd_wen_d = bus.ex_rd_wen;
        f3_d     = bus.ex_funct3;
        lo_d     = bus.ex_addr_lo;
      end else if (bus.ex_valid && bus.ex_rd_wen && bus.ex_rd_num != 5'd0) begin
        wen_d   = 1'b1;
        ma_rd_d = bus.ex_rd_num;
        wdata_d = bus.ex_result;
      end
    end else if (bus.dmem_rvalid) begin
      state_d = IDLE;
      if (rd_wen_q && rd_q != 5'd0) begin
        wen_d   = 1'b1;
        ma_rd_d = rd_q;
        wdata_d = ld_data;
      end
    end else if (cnt_q == 16'(LOAD_TIMEOUT - 1)) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_q     <= '0;
      rd_wen_q <= 1'b0;
      f3_q     <= '0;
      lo_q     <= '0;
      wen_q    <= 1'b0;
      ma_rd_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      rd_wen_q <= rd_wen_d;
      f3_q     <= f3_d;
      lo_q     <= lo_d;
      wen_q    <= wen_d;
      ma_rd_q  <= ma_rd_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_rip_writeback.sv
// tb_rip_writeback: directed vectors against rip_writeback with LOAD_TIMEOUT=4.
module tb_rip_writeback;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  rip_writeback_if bus ();
  rip_writeback #(.LOAD_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic alu(input logic wen_i, input logic [4:0] rd, input logic [31:0] res);
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b0; bus.ex_rd_wen = wen_i;
    bus.ex_rd_num = rd; bus.ex_result = res;
    step();
    bus.ex_valid = 1'b0;
  endtask
  // rvalid is sampled on the (waits+1)-th WAIT_LOAD cycle
  task automatic load(input logic wen_i, input logic [4:0] rd, input logic [2:0] f3,
                      input logic [1:0] lo, input int waits, input logic [31:0] d);
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd_wen = wen_i;
    bus.ex_rd_num = rd; bus.ex_funct3 = f3; bus.ex_addr_lo = lo;
    step();
    bus.ex_valid = 1'b0; bus.ex_is_load = 1'b0;
    chk("ld_busy", 32'(bus.wb_ready), 0);
    chk("ld_pend_valid", 32'(bus.pend_valid), 1);
    chk("ld_pend_rd", 32'(bus.pend_rd_num), 32'(rd));
    repeat (waits) step();
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = d;
    step();
    bus.dmem_rvalid = 1'b0;
    chk("ld_done_ready", 32'(bus.wb_ready), 1);
    chk("ld_done_pend", 32'(bus.pend_valid), 0);
  endtask
  initial begin
    bus.ex_valid = 0; bus.ex_rd_wen = 0; bus.ex_rd_num = 0; bus.ex_is_load = 0;
    bus.ex_funct3 = 0; bus.ex_addr_lo = 0; bus.ex_result = 0;
    bus.dmem_rvalid = 0; bus.dmem_rdata = 0;
    step(); step();
    chk("rst_wen", 32'(bus.wen), 0);
    chk("rst_rd", 32'(bus.ma_rd_num), 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_pend", 32'(bus.pend_valid), 0);
    chk("rst_pend_rd", 32'(bus.pend_rd_num), 0);
    chk("rst_err", 32'(bus.err_timeout), 0);
    rst = 1'b0;
    chk("rel_ready", 32'(bus.wb_ready), 1);
    alu(1'b1, 5'd5, 32'hDEADBEEF);
    chk("alu_wen", 32'(bus.wen), 1);
    chk("alu_rd", 32'(bus.ma_rd_num), 5);
    chk("alu_wdata", bus.wdata, 32'hDEADBEEF);
    step();
    chk("alu_pulse", 32'(bus.wen), 0);
    chk("alu_hold", bus.wdata, 32'hDEADBEEF);
    // LB with rvalid in the 4th wait cycle, which is also the timeout cycle
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd_wen = 1'b1;
    bus.ex_rd_num = 5'd7; bus.ex_funct3 = 3'd0; bus.ex_addr_lo = 2'd3;
    step();
    chk("lb_busy", 32'(bus.wb_ready), 0);
    chk("lb_pend_rd", 32'(bus.pend_rd_num), 7);
    bus.ex_is_load = 1'b0; bus.ex_rd_num = 5'd9; bus.ex_result = 32'h11111111;
    step(); step();
    chk("lb_stall_ready", 32'(bus.wb_ready), 0);
    chk("lb_stall_wen", 32'(bus.wen), 0);
    step();
    bus.ex_valid = 1'b0;
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h80123456;
    step();
    bus.dmem_rvalid = 1'b0;
    chk("lb_wen", 32'(bus.wen), 1);
    chk("lb_rd", 32'(bus.ma_rd_num), 7);
    chk("lb_wdata", bus.wdata, 32'hFFFFFF80);
    chk("lb_race_err", 32'(bus.err_timeout), 0);
    chk("lb_ready", 32'(bus.wb_ready), 1);
    step();
    chk("lb_pulse", 32'(bus.wen), 0);
    chk("stall_ignored", 32'(bus.ma_rd_num), 7);
    load(1'b1, 5'd3, 3'd5, 2'd2, 0, 32'hF00D1234);
    chk("lhu_wdata", bus.wdata, 32'h0000F00D);
    chk("lhu_rd", 32'(bus.ma_rd_num), 3);
    load(1'b1, 5'd4, 3'd1, 2'd3, 1, 32'hF00D1234);
    chk("lh_wdata", bus.wdata, 32'hFFFFF00D);
    load(1'b1, 5'd2, 3'd4, 2'd1, 2, 32'h0000A500);
    chk("lbu_wdata", bus.wdata, 32'h000000A5);
    load(1'b1, 5'd6, 3'd1, 2'd0, 0, 32'h12348765);
    chk("lh_lo_wdata", bus.wdata, 32'hFFFF8765);
    load(1'b1, 5'd11, 3'd2, 2'd1, 0, 32'hCAFEF00D);
    chk("lw_wdata", bus.wdata, 32'hCAFEF00D);
    load(1'b1, 5'd12, 3'd7, 2'd3, 0, 32'h8BADF00D);
    chk("f7_wdata", bus.wdata, 32'h8BADF00D);
    chk("f7_wen", 32'(bus.wen), 1);
    alu(1'b1, 5'd0, 32'h55555555);
    chk("x0_alu_wen", 32'(bus.wen), 0);
    step();
    chk("x0_alu_wen2", 32'(bus.wen), 0);
    alu(1'b0, 5'd9, 32'h55555555);
    chk("nowen_alu", 32'(bus.wen), 0);
    load(1'b1, 5'd0, 3'd2, 2'd0, 2, 32'h77777777);
    chk("x0_ld_wen", 32'(bus.wen), 0);
    chk("x0_ld_hold", bus.wdata, 32'h8BADF00D);
    load(1'b0, 5'd13, 3'd2, 2'd0, 0, 32'h66666666);
    chk("nowen_ld", 32'(bus.wen), 0);
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h44444444;
    step();
    bus.dmem_rvalid = 1'b0;
    chk("idle_rvalid_wen", 32'(bus.wen), 0);
    chk("idle_rvalid_ready", 32'(bus.wb_ready), 1);
    // timeout: four WAIT_LOAD cycles with no response
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd_wen = 1'b1;
    bus.ex_rd_num = 5'd8; bus.ex_funct3 = 3'd2;
    step();
    bus.ex_valid = 1'b0; bus.ex_is_load = 1'b0;
    step(); step(); step();
    chk("to_w4_ready", 32'(bus.wb_ready), 0);
    chk("to_w4_err", 32'(bus.err_timeout), 0);
    step();
    chk("to_err", 32'(bus.err_timeout), 1);
    chk("to_ready", 32'(bus.wb_ready), 1);
    chk("to_pend", 32'(bus.pend_valid), 0);
    chk("to_wen", 32'(bus.wen), 0);
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h33333333;
    step();
    bus.dmem_rvalid = 1'b0;
    chk("to_late_wen", 32'(bus.wen), 0);
    chk("to_late_wdata", bus.wdata, 32'h8BADF00D);
    alu(1'b1, 5'd14, 32'h00000042);
    chk("to_sticky", 32'(bus.err_timeout), 1);
    chk("post_to_wdata", bus.wdata, 32'h00000042);
    // reset in the middle of a load
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd_wen = 1'b1; bus.ex_rd_num = 5'd10;
    step();
    bus.ex_valid = 1'b0; bus.ex_is_load = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h22222222;
    step();
    bus.dmem_rvalid = 1'b0;
    chk("mr_wen", 32'(bus.wen), 0);
    chk("mr_rd", 32'(bus.ma_rd_num), 0);
    chk("mr_wdata", bus.wdata, 0);
    chk("mr_pend", 32'(bus.pend_valid), 0);
    chk("mr_pend_rd", 32'(bus.pend_rd_num), 0);
    chk("mr_err", 32'(bus.err_timeout), 0);
    chk("mr_ready", 32'(bus.wb_ready), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/rip_writeback.md
RIP_WRITEBACK -- requirements
Module: rip_writeback

Interface
REQ-001 Parameter LOAD_TIMEOUT, default 255, meaning max cycles spent in WAIT_LOAD before abort; legal range 1..65535.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 ex_valid  input  1  EX/MA stage presents an instruction this cycle.
REQ-005 ex_rd_wen  input  1  instruction writes a destination register.
REQ-006 ex_rd_num  input  5  destination register number.
REQ-007 ex_is_load  input  1  instruction is a load; the result comes from dmem_rdata.
REQ-008 ex_funct3  input  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
REQ-009 ex_addr_lo  input  2  load address bits [1:0].
REQ-010 ex_result  input  32  ALU/CSR result for non-load instructions.
REQ-011 dmem_rvalid  input  1  data memory read response valid.
REQ-012 dmem_rdata  input  32  data memory read word, naturally aligned.
REQ-013 wb_ready  output  1  block accepts ex_valid this cycle; combinational, equals (state==IDLE).
REQ-014 wen  output  1  register file write enable, registered.
REQ-015 ma_rd_num  output  5  register file write index, registered.
REQ-016 wdata  output  32  register file write data, registered.
REQ-017 pend_valid  output  1  a load is outstanding; used for hazard detection.
REQ-018 pend_rd_num  output  5  destination register of the outstanding load.
REQ-019 err_timeout  output  1  sticky load-timeout flag.

Function
REQ-020 States: IDLE and WAIT_LOAD; an instruction is accepted only when ex_valid && wb_ready.
REQ-021 Accepted non-load instruction with ex_rd_wen=1 and ex_rd_num!=0: next cycle wen=1, ma_rd_num=ex_rd_num, wdata=ex_result; state stays IDLE.
REQ-022 Accepted instruction with ex_rd_wen=0 or ex_rd_num=0: next cycle wen=0; no other effect.
REQ-023 wen is a single-cycle pulse; wen=0 in every cycle without a write, while ma_rd_num and wdata hold their last value.
REQ-024 Accepted load: capture rd_num, rd_wen, funct3 and addr_lo; go to WAIT_LOAD next cycle; pend_valid=1 and pend_rd_num=captured rd from that cycle on.
REQ-025 A load with rd=0 or rd_wen=0 still waits for its response; the completion cycle then has wen=0.
REQ-026 In WAIT_LOAD with dmem_rvalid=1: next cycle wen=1 (subject to REQ-025), wdata=extended data, and state is IDLE; pend_valid drops to 0 in that same next cycle.
REQ-027 Extension, LB/LBU: byte dmem_rdata[8*addr_lo+7 -: 8], sign-extended for LB and zero-extended for LBU.
REQ-028 Extension, LH/LHU: half dmem_rdata[16*addr_lo[1]+15 -: 16] with addr_lo[0] ignored, sign-extended for LH and zero-extended for LHU.
REQ-029 Extension, LW and funct3 values 3, 6, 7: full dmem_rdata.
REQ-030 dmem_rvalid in IDLE is ignored: no write and no state change.
REQ-031 ex_valid while wb_ready=0 is not accepted and has no effect; upstream holds the instruction.
REQ-032 The timeout counter clears on entry to WAIT_LOAD and increments each WAIT_LOAD cycle without dmem_rvalid.
REQ-033 When the counter reaches LOAD_TIMEOUT: next cycle err_timeout=1, state=IDLE, pend_valid=0, and no write occurs.
REQ-034 If dmem_rvalid arrives in the same cycle the counter reaches LOAD_TIMEOUT, the response wins: the write occurs and err_timeout is unchanged.
REQ-035 err_timeout stays set until reset.

Reset
REQ-036 While rst=1: state=IDLE, wen=0, ma_rd_num=0, wdata=0, pend_valid=0, pend_rd_num=0, err_timeout=0, counter=0.
REQ-037 Reset asserted during WAIT_LOAD abandons the load; a dmem_rvalid arriving after reset release is ignored per REQ-030.
REQ-038 wb_ready=1 in the first cycle after reset release.

Verification
REQ-039 ALU op: rd=5, result=0xDEADBEEF -> one cycle later wen=1, ma_rd_num=5, wdata=0xDEADBEEF; the cycle after that, wen=0.
REQ-040 LB: rd=7, addr_lo=3, rvalid 4 cycles later with rdata=0x80123456 -> wb_ready=0 and pend_rd_num=7 while waiting; then wen=1, wdata=0xFFFFFF80.
REQ-041 LHU: addr_lo=2, rdata=0xF00D1234 -> wdata=0x0000F00D; LH with the same stimulus -> wdata=0xFFFFF00D.
REQ-042 Write to x0: ALU op with rd=0 -> wen never asserts; load with rd=0 -> wb_ready=0 until rvalid, then wen=0.
REQ-043 Timeout: LOAD_TIMEOUT=4, no rvalid -> err_timeout=1 and wb_ready=1 after the 4th WAIT cycle; no write; a late rvalid is ignored.
REQ-044 Reset mid-load: rst pulsed during WAIT_LOAD, then rvalid -> all outputs 0, no write, wb_ready=1.
